eth_frame_gen: RTL and testbench
================================

ETH_FRAME_GEN -- requirements
Module: eth_frame_gen

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, payload width in bits: 8, 16, 32 or 64.
REQ-002 The block SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, byte-enable width.
REQ-003 The block SHALL have parameter LOCAL_MAC, default 48'h02_00_00_00_00_00, driven on m_eth_src_mac.
REQ-004 The block SHALL have parameter DST_MAC, default 48'hFF_FF_FF_FF_FF_FF, driven on m_eth_dest_mac.
REQ-005 The block SHALL have parameter ETH_TYPE, default 16'h88B5, driven on m_eth_type.
REQ-006 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  sole clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse, begins a run when idle.
- stop  in  1  one-cycle pulse, ends run after current frame.
- cfg_length  in  16  payload bytes per frame.
- cfg_count  in  16  frames per run; 0 = continuous.
- cfg_gap  in  16  idle cycles between frames.
- cfg_mode  in  2  0 incrementing, 1 constant, 2 PRBS8, 3 reserved (treated as 0).
- cfg_fill  in  8  byte for mode 1.
- m_eth_hdr_valid / m_eth_hdr_ready  out / in  1 each  header handshake.
- m_eth_dest_mac, m_eth_src_mac  out  48 each; m_eth_type  out  16.
- m_eth_payload_axis_tdata  out  DATA_WIDTH; _tkeep  out  KEEP_WIDTH; _tvalid  out  1; _tready  in  1; _tlast  out  1; _tuser  out  1 (always 0).
- busy  out  1  high from start acceptance until return to IDLE.
- frames_sent  out  32  count of completed frames, wraps at 2^32.

Function
REQ-007 FSM states SHALL be IDLE, HDR, PAYLOAD, GAP.
REQ-008 In IDLE, start SHALL latch all cfg_* inputs and enter HDR the next cycle; start outside IDLE SHALL be ignored.
REQ-009 A run SHALL be refused (stay IDLE, busy low) if latched cfg_length is 0.
REQ-010 HDR SHALL assert m_eth_hdr_valid with stable header fields until m_eth_hdr_ready, then enter PAYLOAD the next cycle.
REQ-011 PAYLOAD SHALL emit ceil(cfg_length/KEEP_WIDTH) beats; byte 0 of the frame in tdata[7:0]; tdata/tkeep/tlast held stable while tvalid && !tready.
REQ-012 tkeep SHALL be all-ones except on the last beat, where only the low (cfg_length mod KEEP_WIDTH, or KEEP_WIDTH if 0) bits are set; tlast SHALL be high only on the last beat.
REQ-013 Mode 0 byte n SHALL be n[7:0], restarting at 0 each frame; mode 1 every byte SHALL be cfg_fill.
REQ-014 Mode 2 SHALL use an 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, seeded 8'hFF at each frame start; byte n is the state after n advances (byte 0 = 8'hFF), KEEP_WIDTH advances per beat.
REQ-015 On the last-beat handshake frames_sent SHALL increment; the block SHALL then enter IDLE if the run is complete or stop was seen during the run, else GAP.
REQ-016 GAP SHALL last exactly cfg_gap cycles then enter HDR; cfg_gap 0 SHALL enter HDR on the cycle after tlast handshake.
REQ-017 stop in HDR before hdr handshake SHALL return to IDLE without emitting the header; stop in GAP SHALL return to IDLE next cycle.
REQ-018 stop and start in the same IDLE cycle: start SHALL win, stop ignored.
REQ-019 Continuous mode (cfg_count 0) SHALL run until stop.

Reset
REQ-020 rst_n low SHALL immediately force IDLE; hdr_valid, tvalid, tlast, tdata, tkeep, busy = 0; frames_sent = 0; LFSR = 8'hFF.
REQ-021 Reset mid-frame SHALL truncate the frame with no tlast; no recovery is attempted.

Configuration
REQ-022 With ETH_FRAME_GEN_SEQ_EN defined, payload bytes 0-3 SHALL carry frames_sent (value before increment) big-endian, overriding the pattern; pattern counter/LFSR still advance; cfg_length < 4 truncates the field.
REQ-023 Without ETH_FRAME_GEN_SEQ_EN, all payload bytes SHALL follow the pattern and no sequence logic SHALL be synthesised.

Verification
REQ-024 DATA_WIDTH 8, mode 0, length 5, count 2, gap 3, ready always high -> two frames, bytes 00..04, exactly 3 idle cycles between, frames_sent 2, busy low after.
REQ-025 DATA_WIDTH 32, length 6 -> beats tkeep 4'hF then 4'h3, tlast on beat 2 only.
REQ-026 Mode 2, DATA_WIDTH 8, length 4 -> bytes FF, FE, FC, F8 (per REQ-014 taps) each frame; random tready stalls keep data stable.
REQ-027 count 0, stop pulsed mid-payload of frame 3 -> frame 3 completes with tlast, then IDLE, frames_sent 3.
REQ-028 rst_n low mid-payload -> all outputs 0 same cycle; after release start with length 0 -> busy stays low.
REQ-029 ETH_FRAME_GEN_SEQ_EN, length 8, count 2 -> frame 2 bytes 0-3 = 00 00 00 01, bytes 4-7 = 04..07 in mode 0.

Source files
------------

// File: rtl/eth_frame_gen.sv
`default_nettype none
// ============================================================================
//  Module      : eth_frame_gen
//  Description : Ethernet test-frame generator. Emits a header handshake and
//                then a payload stream (incrementing, constant or PRBS8
//                pattern) for a configurable number of frames, with a
//                configurable idle gap between frames.
//                Optional feature macro: ETH_FRAME_GEN_SEQ_EN. When defined,
//                payload bytes 0-3 carry the frame sequence number.
//  Revision    : 1.0 - initial release
// ============================================================================
module eth_frame_gen #(
    parameter int          DATA_WIDTH = 8,
    parameter int          KEEP_WIDTH = DATA_WIDTH / 8,
    parameter logic [47:0] LOCAL_MAC  = 48'h02_00_00_00_00_00,
    parameter logic [47:0] DST_MAC    = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [15:0] ETH_TYPE   = 16'h88B5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic [15:0]           cfg_length,
    input  logic [15:0]           cfg_count,
    input  logic [15:0]           cfg_gap,
    input  logic [1:0]            cfg_mode,
    input  logic [7:0]            cfg_fill,
    output logic                  m_eth_hdr_valid,
    input  logic                  m_eth_hdr_ready,
    output logic [47:0]           m_eth_dest_mac,
    output logic [47:0]           m_eth_src_mac,
    output logic [15:0]           m_eth_type,
    output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_eth_payload_axis_tkeep,
    output logic                  m_eth_payload_axis_tvalid,
    input  logic                  m_eth_payload_axis_tready,
    output logic                  m_eth_payload_axis_tlast,
    output logic                  m_eth_payload_axis_tuser,
    output logic                  busy,
    output logic [31:0]           frames_sent
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_GAP     = 2'd3
    } state_t;

    localparam logic [7:0] c_lfsr_seed = 8'hFF;

    state_t r_state;
    state_t w_state_next;

    // Run configuration captured at start
    logic [15:0] r_len;
    logic [15:0] r_count;
    logic [15:0] r_gap;
    logic [1:0]  r_mode;
    logic [7:0]  r_fill;

    // Run progress
    logic [15:0] r_byte_idx;      // frame byte index of the current beat's byte 0
    logic [15:0] r_run_frames;    // frames completed in this run
    logic [15:0] r_gap_cnt;
    logic        r_stop_seen;
    logic [7:0]  r_lfsr;          // LFSR state for the current beat's byte 0
    logic [31:0] r_frames_sent;

    logic [15:0]           w_remaining;
    logic                  w_last_beat;
    logic                  w_beat_fire;
    logic                  w_run_done;
    logic [DATA_WIDTH-1:0] w_data;
    logic [KEEP_WIDTH-1:0] w_keep;
    logic [7:0]            w_lfsr_walk;
    logic [7:0]            w_lfsr_next;
    logic [7:0]            w_byte;
    logic [7:0]            w_byte_lo;

    // x^8 + x^6 + x^5 + x^4 + 1, shifting towards the MSB
    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    assign w_remaining = r_len - r_byte_idx;
    assign w_last_beat = (w_remaining <= 16'(KEEP_WIDTH));
    assign w_beat_fire = (r_state == ST_PAYLOAD) && m_eth_payload_axis_tready;
    assign w_run_done  = r_stop_seen || stop ||
                         ((r_count != 16'd0) && ((r_run_frames + 16'd1) == r_count));

    // Build the lanes of the current beat and the LFSR state for the next beat
    always_comb begin
        w_data      = '0;
        w_keep      = '0;
        w_byte      = 8'h00;
        w_byte_lo   = 8'h00;
        w_lfsr_walk = r_lfsr;
        for (int k = 0; k < KEEP_WIDTH; k++) begin
            w_byte_lo = r_byte_idx[7:0] + 8'(k);
            case (r_mode)
                2'd1:    w_byte = r_fill;
                2'd2:    w_byte = w_lfsr_walk;
                default: w_byte = w_byte_lo;
            endcase
`ifdef ETH_FRAME_GEN_SEQ_EN
            // Sequence number overrides the pattern on bytes 0-3, big-endian
            if ((r_byte_idx + 16'(k)) < 16'd4) begin
                case (w_byte_lo[1:0])
                    2'd0:    w_byte = r_frames_sent[31:24];
                    2'd1:    w_byte = r_frames_sent[23:16];
                    2'd2:    w_byte = r_frames_sent[15:8];
                    default: w_byte = r_frames_sent[7:0];
                endcase
            end
`endif
            w_data[8*k +: 8] = w_byte;
            w_keep[k]        = (16'(k) < w_remaining);
            w_lfsr_walk      = lfsr_step(w_lfsr_walk);
        end
        w_lfsr_next = w_lfsr_walk;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start && (cfg_length != 16'd0)) begin
                    w_state_next = ST_HDR;
                end
            end
            ST_HDR: begin
                // A completed header handshake wins over a simultaneous stop
                if (m_eth_hdr_ready) begin
                    w_state_next = ST_PAYLOAD;
                end else if (stop) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                if (w_beat_fire && w_last_beat) begin
                    if (w_run_done) begin
                        w_state_next = ST_IDLE;
                    end else if (r_gap == 16'd0) begin
                        w_state_next = ST_HDR;
                    end else begin
                        w_state_next = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (stop) begin
                    w_state_next = ST_IDLE;
                end else if (r_gap_cnt <= 16'd1) begin
                    w_state_next = ST_HDR;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Configuration capture, beat/frame progress and the pattern generator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len         <= 16'd0;
            r_count       <= 16'd0;
            r_gap         <= 16'd0;
            r_mode        <= 2'd0;
            r_fill        <= 8'h00;
            r_byte_idx    <= 16'd0;
            r_run_frames  <= 16'd0;
            r_gap_cnt     <= 16'd0;
            r_stop_seen   <= 1'b0;
            r_lfsr        <= c_lfsr_seed;
            r_frames_sent <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_len        <= cfg_length;
                        r_count      <= cfg_count;
                        r_gap        <= cfg_gap;
                        r_mode       <= cfg_mode;
                        r_fill       <= cfg_fill;
                        r_byte_idx   <= 16'd0;
                        r_run_frames <= 16'd0;
                        r_stop_seen  <= 1'b0;
                        r_lfsr       <= c_lfsr_seed;
                    end
                end
                ST_HDR: begin
                    if (stop) begin
                        r_stop_seen <= 1'b1;
                    end
                end
                ST_PAYLOAD: begin
                    if (stop) begin
                        r_stop_seen <= 1'b1;
                    end
                    if (w_beat_fire) begin
                        if (w_last_beat) begin
                            r_byte_idx    <= 16'd0;
                            r_lfsr        <= c_lfsr_seed;
                            r_frames_sent <= r_frames_sent + 32'd1;
                            r_run_frames  <= r_run_frames + 16'd1;
                            r_gap_cnt     <= r_gap;
                        end else begin
                            r_byte_idx <= r_byte_idx + 16'(KEEP_WIDTH);
                            r_lfsr     <= w_lfsr_next;
                        end
                    end
                end
                ST_GAP: begin
                    r_gap_cnt <= r_gap_cnt - 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign busy                      = (r_state != ST_IDLE);
    assign frames_sent               = r_frames_sent;
    assign m_eth_hdr_valid           = (r_state == ST_HDR);
    assign m_eth_dest_mac            = DST_MAC;
    assign m_eth_src_mac             = LOCAL_MAC;
    assign m_eth_type                = ETH_TYPE;
    assign m_eth_payload_axis_tvalid = (r_state == ST_PAYLOAD);
    assign m_eth_payload_axis_tdata  = m_eth_payload_axis_tvalid ? w_data : '0;
    assign m_eth_payload_axis_tkeep  = m_eth_payload_axis_tvalid ? w_keep : '0;
    assign m_eth_payload_axis_tlast  = m_eth_payload_axis_tvalid && w_last_beat;
    assign m_eth_payload_axis_tuser  = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_eth_frame_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_eth_frame_gen
//  Description : Directed self-checking bench for eth_frame_gen, with one
//                8-bit and one 32-bit instance sharing stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_frame_gen;

`ifdef ETH_FRAME_GEN_SEQ_EN
    localparam bit SEQ_ON = 1'b1;
`else
    localparam bit SEQ_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, stop;
    logic [15:0] cfg_length, cfg_count, cfg_gap;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_fill;
    logic        hdr_ready8, tready8, hdr_ready32, tready32;

    logic        hdr_valid8, tvalid8, tlast8, tuser8, busy8;
    logic [47:0] dest8, src8;
    logic [15:0] type8;
    logic [7:0]  tdata8;
    logic [0:0]  tkeep8;
    logic [31:0] fs8;

    logic        hdr_valid32, tvalid32, tlast32, tuser32, busy32;
    logic [47:0] dest32, src32;
    logic [15:0] type32;
    logic [31:0] tdata32;
    logic [3:0]  tkeep32;
    logic [31:0] fs32;

    int n_cmp = 0;
    int n_err = 0;

    eth_frame_gen #(.DATA_WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .cfg_length(cfg_length), .cfg_count(cfg_count), .cfg_gap(cfg_gap),
        .cfg_mode(cfg_mode), .cfg_fill(cfg_fill),
        .m_eth_hdr_valid(hdr_valid8), .m_eth_hdr_ready(hdr_ready8),
        .m_eth_dest_mac(dest8), .m_eth_src_mac(src8), .m_eth_type(type8),
        .m_eth_payload_axis_tdata(tdata8), .m_eth_payload_axis_tkeep(tkeep8),
        .m_eth_payload_axis_tvalid(tvalid8), .m_eth_payload_axis_tready(tready8),
        .m_eth_payload_axis_tlast(tlast8), .m_eth_payload_axis_tuser(tuser8),
        .busy(busy8), .frames_sent(fs8)
    );

    eth_frame_gen #(.DATA_WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .cfg_length(cfg_length), .cfg_count(cfg_count), .cfg_gap(cfg_gap),
        .cfg_mode(cfg_mode), .cfg_fill(cfg_fill),
        .m_eth_hdr_valid(hdr_valid32), .m_eth_hdr_ready(hdr_ready32),
        .m_eth_dest_mac(dest32), .m_eth_src_mac(src32), .m_eth_type(type32),
        .m_eth_payload_axis_tdata(tdata32), .m_eth_payload_axis_tkeep(tkeep32),
        .m_eth_payload_axis_tvalid(tvalid32), .m_eth_payload_axis_tready(tready32),
        .m_eth_payload_axis_tlast(tlast32), .m_eth_payload_axis_tuser(tuser32),
        .busy(busy32), .frames_sent(fs32)
    );

    // Expected payload byte n of a frame, given frames completed before it
    function automatic logic [7:0] exp_byte(input int fs, input int n, input logic [7:0] pat);
        logic [31:0] f;
        f = fs;
        exp_byte = pat;
        if (SEQ_ON && n < 4) exp_byte = f[8*(3-n) +: 8];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 1'b0;
        stop  = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic set_cfg(input int len, input int cnt, input int gap, input int mode, input logic [7:0] fill);
        cfg_length = 16'(len);
        cfg_count  = 16'(cnt);
        cfg_gap    = 16'(gap);
        cfg_mode   = 2'(mode);
        cfg_fill   = fill;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({hdr_valid8, tvalid8, tlast8, busy8, tuser8} !== 5'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b want 00000", {hdr_valid8, tvalid8, tlast8, busy8, tuser8});
        end
        n_cmp++;
        if ({tdata8, tkeep8, fs8} !== 41'd0) begin
            n_err++; $display("FAIL reset_data: got tdata %h tkeep %b fs %0d want 0", tdata8, tkeep8, fs8);
        end
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++;
        if (busy8 !== 1'b0 || busy32 !== 1'b0) begin
            n_err++; $display("FAIL reset_busy: got %b%b want 00", busy8, busy32);
        end
    endtask

    task automatic test_basic();
        int beat, frames, gapc, cyc;
        bit in_gap, hdr_checked;
        do_reset();
        set_cfg(5, 2, 3, 0, 8'h00);
        pulse_start();
        beat = 0; frames = 0; gapc = 0; cyc = 0; in_gap = 0; hdr_checked = 0;
        while (frames < 2 && cyc < 200) begin
            if (hdr_valid8 && !hdr_checked) begin
                hdr_checked = 1;
                n_cmp++;
                if ({dest8, src8, type8} !== {48'hFFFF_FFFF_FFFF, 48'h0200_0000_0000, 16'h88B5}) begin
                    n_err++; $display("FAIL basic_hdr: got %h %h %h", dest8, src8, type8);
                end
            end
            if (in_gap) begin
                if (hdr_valid8) begin
                    in_gap = 0;
                    n_cmp++;
                    if (gapc !== 3) begin
                        n_err++; $display("FAIL basic_gap: got %0d idle cycles want 3", gapc);
                    end
                end else if (!tvalid8) begin
                    gapc++;
                end
            end
            if (tvalid8) begin
                n_cmp++;
                if (tdata8 !== exp_byte(frames, beat, 8'(beat)) || tlast8 !== (beat == 4)) begin
                    n_err++; $display("FAIL basic_beat: frame %0d beat %0d got %h/%b want %h/%b",
                                      frames, beat, tdata8, tlast8, exp_byte(frames, beat, 8'(beat)), beat == 4);
                end
                if (tready8) begin
                    if (beat == 4) begin beat = 0; frames++; in_gap = 1; gapc = 0; end
                    else beat++;
                end
            end
            tick();
            cyc++;
        end
        if (cyc >= 200) begin n_cmp++; n_err++; $display("FAIL basic_timeout: got %0d frames want 2", frames); end
        n_cmp++;
        if (busy8 !== 1'b0 || fs8 !== 32'd2) begin
            n_err++; $display("FAIL basic_end: got busy %b fs %0d want busy 0 fs 2", busy8, fs8);
        end
    endtask

    task automatic test_keep32();
        int beat, cyc;
        do_reset();
        set_cfg(6, 1, 0, 0, 8'h00);
        pulse_start();
        beat = 0; cyc = 0;
        while (beat < 2 && cyc < 30) begin
            if (tvalid32) begin
                n_cmp++;
                if (beat == 0) begin
                    if (tkeep32 !== 4'hF || tlast32 !== 1'b0 ||
                        tdata32 !== {exp_byte(0, 3, 8'h03), exp_byte(0, 2, 8'h02), exp_byte(0, 1, 8'h01), exp_byte(0, 0, 8'h00)}) begin
                        n_err++; $display("FAIL keep32_beat0: got %h %h %b want keep F tlast 0", tdata32, tkeep32, tlast32);
                    end
                end else begin
                    if (tkeep32 !== 4'h3 || tlast32 !== 1'b1 || tdata32[15:0] !== 16'h0504) begin
                        n_err++; $display("FAIL keep32_beat1: got %h %h %b want 0504 3 1", tdata32, tkeep32, tlast32);
                    end
                end
                beat++;
            end
            tick();
            cyc++;
        end
        n_cmp++;
        if (beat !== 2 || busy32 !== 1'b0 || fs32 !== 32'd1) begin
            n_err++; $display("FAIL keep32_end: got beats %0d busy %b fs %0d want 2 0 1", beat, busy32, fs32);
        end
    endtask

    task automatic test_prbs();
        logic [7:0] exp_b [4];
        int beat, frames, cyc, stalls;
        exp_b[0] = 8'hFF; exp_b[1] = 8'hFE; exp_b[2] = 8'hFC; exp_b[3] = 8'hF8;
        do_reset();
        set_cfg(4, 2, 1, 2, 8'h00);
        pulse_start();
        beat = 0; frames = 0; cyc = 0; stalls = 0;
        while (frames < 2 && cyc < 300) begin
            tready8 = 1'($urandom_range(0, 1));
            if (tvalid8) begin
                n_cmp++;
                if (tdata8 !== exp_byte(frames, beat, exp_b[beat]) || tlast8 !== (beat == 3)) begin
                    n_err++; $display("FAIL prbs_beat: frame %0d beat %0d got %h/%b want %h/%b",
                                      frames, beat, tdata8, tlast8, exp_byte(frames, beat, exp_b[beat]), beat == 3);
                end
                if (tready8) begin
                    if (beat == 3) begin beat = 0; frames++; end
                    else beat++;
                end else begin
                    stalls++;
                end
            end
            tick();
            cyc++;
        end
        tready8 = 1'b1;
        n_cmp++;
        if (frames !== 2 || fs8 !== 32'd2 || busy8 !== 1'b0) begin
            n_err++; $display("FAIL prbs_end: got frames %0d fs %0d busy %b (stalls %0d) want 2 2 0", frames, fs8, busy8, stalls);
        end
    endtask

    task automatic test_fill_reserved();
        int beat, cyc;
        logic [7:0] pat;
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            set_cfg(3, 1, 0, (pass == 0) ? 1 : 3, 8'hA5);
            pulse_start();
            beat = 0; cyc = 0;
            while (beat < 3 && cyc < 30) begin
                if (tvalid8) begin
                    pat = (pass == 0) ? 8'hA5 : 8'(beat);
                    n_cmp++;
                    if (tdata8 !== exp_byte(pass, beat, pat) || tlast8 !== (beat == 2)) begin
                        n_err++; $display("FAIL mode_beat: pass %0d beat %0d got %h/%b want %h/%b",
                                          pass, beat, tdata8, tlast8, exp_byte(pass, beat, pat), beat == 2);
                    end
                    beat++;
                end
                tick();
                cyc++;
            end
            n_cmp++;
            if (beat !== 3 || busy8 !== 1'b0) begin
                n_err++; $display("FAIL mode_end: pass %0d got beats %0d busy %b want 3 0", pass, beat, busy8);
            end
        end
    endtask

    task automatic test_stop_continuous();
        int beat, frames, cyc, hdrs;
        bit stopped;
        do_reset();
        set_cfg(5, 0, 2, 0, 8'h00);
        pulse_start();
        beat = 0; frames = 0; cyc = 0; stopped = 0;
        while (frames < 3 && cyc < 400) begin
            stop = 1'b0;
            if (tvalid8) begin
                if (frames == 2 && beat == 2 && !stopped) begin
                    stop = 1'b1;
                    stopped = 1;
                end
                n_cmp++;
                if (tdata8 !== exp_byte(frames, beat, 8'(beat)) || tlast8 !== (beat == 4)) begin
                    n_err++; $display("FAIL cont_beat: frame %0d beat %0d got %h/%b want %h/%b",
                                      frames, beat, tdata8, tlast8, exp_byte(frames, beat, 8'(beat)), beat == 4);
                end
                if (beat == 4) begin beat = 0; frames++; end
                else beat++;
            end
            tick();
            cyc++;
        end
        stop = 1'b0;
        n_cmp++;
        if (busy8 !== 1'b0 || fs8 !== 32'd3) begin
            n_err++; $display("FAIL cont_end: got busy %b fs %0d want busy 0 fs 3", busy8, fs8);
        end
        hdrs = 0;
        for (int i = 0; i < 10; i++) begin
            if (hdr_valid8) hdrs++;
            tick();
        end
        n_cmp++;
        if (hdrs !== 0) begin
            n_err++; $display("FAIL cont_after_stop: got %0d header cycles want 0", hdrs);
        end
    endtask

    task automatic test_stop_hdr_gap();
        int cyc;
        do_reset();
        hdr_ready8 = 1'b0;
        hdr_ready32 = 1'b0;
        set_cfg(4, 1, 0, 0, 8'h00);
        pulse_start();
        n_cmp++;
        if (hdr_valid8 !== 1'b1 || busy8 !== 1'b1) begin
            n_err++; $display("FAIL hdr_wait: got hdr_valid %b busy %b want 1 1", hdr_valid8, busy8);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_cmp++;
        if (hdr_valid8 !== 1'b0 || busy8 !== 1'b0 || tvalid8 !== 1'b0) begin
            n_err++; $display("FAIL hdr_stop: got hdr_valid %b busy %b tvalid %b want 0 0 0", hdr_valid8, busy8, tvalid8);
        end
        // start and stop together in IDLE: start wins
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        n_cmp++;
        if (busy8 !== 1'b1 || hdr_valid8 !== 1'b1) begin
            n_err++; $display("FAIL start_stop: got busy %b hdr_valid %b want 1 1", busy8, hdr_valid8);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        // stop during the inter-frame gap
        hdr_ready8 = 1'b1;
        hdr_ready32 = 1'b1;
        set_cfg(2, 0, 5, 0, 8'h00);
        pulse_start();
        cyc = 0;
        while (!(tvalid8 && tlast8) && cyc < 30) begin
            tick();
            cyc++;
        end
        tick();
        n_cmp++;
        if (busy8 !== 1'b1 || hdr_valid8 !== 1'b0 || tvalid8 !== 1'b0) begin
            n_err++; $display("FAIL gap_enter: got busy %b hdr %b tvalid %b want 1 0 0", busy8, hdr_valid8, tvalid8);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_cmp++;
        if (busy8 !== 1'b0 || fs8 !== 32'd1) begin
            n_err++; $display("FAIL gap_stop: got busy %b fs %0d want 0 1", busy8, fs8);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        do_reset();
        set_cfg(8, 1, 0, 0, 8'h00);
        pulse_start();
        cyc = 0;
        while (!tvalid8 && cyc < 20) begin
            tick();
            cyc++;
        end
        tick();
        tick();
        n_cmp++;
        if (tvalid8 !== 1'b1 || tdata8 !== exp_byte(0, 2, 8'h02)) begin
            n_err++; $display("FAIL midrst_pre: got tvalid %b tdata %h want 1 %h", tvalid8, tdata8, exp_byte(0, 2, 8'h02));
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({hdr_valid8, tvalid8, tlast8, busy8, tdata8, tkeep8, fs8} !== 45'd0 ||
            {hdr_valid32, tvalid32, tlast32, busy32, tdata32, tkeep32, fs32} !== 72'd0) begin
            n_err++; $display("FAIL midrst_out: got tv %b td %h tk %b busy %b tl %b want all 0",
                              tvalid8, tdata8, tkeep8, busy8, tlast8);
        end
        tick();
        rst_n = 1'b1;
        set_cfg(0, 1, 0, 0, 8'h00);
        pulse_start();
        n_cmp++;
        if (busy8 !== 1'b0 || hdr_valid8 !== 1'b0) begin
            n_err++; $display("FAIL len0_refuse: got busy %b hdr %b want 0 0", busy8, hdr_valid8);
        end
        tick();
        n_cmp++;
        if (busy8 !== 1'b0 || busy32 !== 1'b0) begin
            n_err++; $display("FAIL len0_hold: got busy %b %b want 0 0", busy8, busy32);
        end
    endtask

    task automatic test_seq();
        int beat, frames, cyc;
        do_reset();
        set_cfg(8, 2, 0, 0, 8'h00);
        pulse_start();
        beat = 0; frames = 0; cyc = 0;
        while (frames < 2 && cyc < 100) begin
            if (tvalid8) begin
                n_cmp++;
                if (tdata8 !== exp_byte(frames, beat, 8'(beat))) begin
                    n_err++; $display("FAIL seq_byte: frame %0d byte %0d got %h want %h",
                                      frames, beat, tdata8, exp_byte(frames, beat, 8'(beat)));
                end
                if (beat == 7) begin beat = 0; frames++; end
                else beat++;
            end
            tick();
            cyc++;
        end
        n_cmp++;
        if (frames !== 2 || fs8 !== 32'd2) begin
            n_err++; $display("FAIL seq_end: got frames %0d fs %0d want 2 2", frames, fs8);
        end
    endtask

    initial begin
        start = 1'b0; stop = 1'b0;
        set_cfg(1, 1, 0, 0, 8'h00);
        hdr_ready8 = 1'b1; tready8 = 1'b1;
        hdr_ready32 = 1'b1; tready32 = 1'b1;
        test_reset();
        test_basic();
        test_keep32();
        test_prbs();
        test_fill_reserved();
        test_stop_continuous();
        test_stop_hdr_gap();
        test_reset_mid();
        test_seq();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion want finish before 1ms");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
